// File: rtl/reg_adr_encoder.sv
// reg_adr_encoder: sequential 32-to-5 register-address encoder.
// A multi-hot request mask is OR-ed into a pending set. One address at a
// time is emitted through a single-entry output slot with a valid/ready
// handshake, in fixed priority order, until the set is empty.
module reg_adr_encoder #(
    parameter int PRIO_HIGH = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] req_vec,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [4:0]  out_adr,
    output logic [5:0]  pend_cnt,
    output logic        busy,
    output logic        done
);

    logic [31:0] pend_q, pend_d;
    logic        out_valid_q, out_valid_d;
    logic [4:0]  out_adr_q, out_adr_d;
    logic [5:0]  pend_cnt_q, pend_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        acc;
    logic [31:0] load_vec;
    logic [31:0] cand;
    logic [4:0]  pick;

    // Priority pick: lowest set index, or highest when PRIO_HIGH is set.
    function automatic logic [4:0] prio_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        if (PRIO_HIGH != 0) begin
            for (int i = 0; i < 32; i++)
                if (v[i]) idx = 5'(i);
        end else begin
            for (int i = 31; i >= 0; i--)
                if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic logic [5:0] popcnt(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++)
            n = n + {5'b0, v[i]};
        return n;
    endfunction

    // Next-state: refill the slot when free, hold it under backpressure.
    always_comb begin
        acc       = out_valid_q & out_ready;
        load_vec  = load ? req_vec : 32'h0;
        cand      = pend_q | load_vec;
        pick      = prio_idx(cand);

        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        out_adr_d   = out_adr_q;
        done_d      = 1'b0;

        if (flush) begin
            // The output address is left alone; consumers ignore it when invalid.
            pend_d      = '0;
            out_valid_d = 1'b0;
        end else begin
            done_d = acc & (pend_q == 32'h0) & (load_vec == 32'h0);
            if (!out_valid_q || acc) begin
                if (cand != 32'h0) begin
                    out_adr_d   = pick;
                    out_valid_d = 1'b1;
                    pend_d      = cand & ~(32'h1 << pick);
                end else begin
                    out_valid_d = 1'b0;
                    pend_d      = '0;
                end
            end else begin
                // Stalled address stays put even if a higher-priority bit arrives.
                pend_d = cand;
            end
        end

        pend_cnt_d = popcnt(pend_d) + {5'b0, out_valid_d};
        busy_d     = out_valid_d | (pend_d != 32'h0);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_adr_q   <= '0;
            pend_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_adr_q   <= out_adr_d;
            pend_cnt_q  <= pend_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_adr   = out_adr_q;
    assign pend_cnt  = pend_cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_adr_encoder.sv
// Bench for reg_adr_encoder: two instances (low-first and high-first
// priority) share one stimulus; a set-based reference model is checked
// every cycle, and directed sequences pin literal expected addresses.
module tb_reg_adr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        load = 1'b0;
    logic [31:0] req_vec = '0;
    logic        out_ready = 1'b0;

    logic [1:0]       dv;
    logic [1:0][4:0]  da;
    logic [1:0][5:0]  dc;
    logic [1:0]       db;
    logic [1:0]       dd;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_adr_encoder #(.PRIO_HIGH(0)) u_lo (
        .clk(clk), .reset(reset), .flush(flush), .load(load), .req_vec(req_vec),
        .out_ready(out_ready), .out_valid(dv[0]), .out_adr(da[0]),
        .pend_cnt(dc[0]), .busy(db[0]), .done(dd[0])
    );

    reg_adr_encoder #(.PRIO_HIGH(1)) u_hi (
        .clk(clk), .reset(reset), .flush(flush), .load(load), .req_vec(req_vec),
        .out_ready(out_ready), .out_valid(dv[1]), .out_adr(da[1]),
        .pend_cnt(dc[1]), .busy(db[1]), .done(dd[1])
    );

    // Reference model: a pending set, a one-entry slot, and the done flag.
    logic [31:0] m_set [2];
    logic        m_vld [2];
    int          m_adr [2];
    logic        m_done[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_set[k]  <= '0;
                m_vld[k]  <= 1'b0;
                m_adr[k]  <= 0;
                m_done[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] all;
                logic        taken;
                int          best;
                taken = m_vld[k] && out_ready;
                all   = m_set[k] | (load ? req_vec : 32'h0);
                best  = -1;
                for (int i = 0; i < 32; i++)
                    if (all[i] && (best < 0 || k == 1)) best = i;
                if (flush) begin
                    m_set[k]  <= '0;
                    m_vld[k]  <= 1'b0;
                    m_done[k] <= 1'b0;
                end else begin
                    m_done[k] <= taken && m_set[k] == 0 && !(load && req_vec != 0);
                    if (m_vld[k] && !taken) begin
                        m_set[k] <= all;
                    end else if (best >= 0) begin
                        m_adr[k] <= best;
                        m_vld[k] <= 1'b1;
                        all[best] = 1'b0;
                        m_set[k] <= all;
                    end else begin
                        m_vld[k] <= 1'b0;
                        m_set[k] <= '0;
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int exp_cnt;
            exp_cnt = $countones(m_set[k]) + (m_vld[k] ? 1 : 0);
            n_cmp++;
            if (dv[k] !== m_vld[k] || int'(da[k]) != m_adr[k] ||
                int'(dc[k]) != exp_cnt || db[k] !== (m_vld[k] || m_set[k] != 0) ||
                dd[k] !== m_done[k]) begin
                n_bad++;
                $display("FAIL model[%0d] t=%0t got vld=%0b adr=%0d cnt=%0d busy=%0b done=%0b exp vld=%0b adr=%0d cnt=%0d done=%0b",
                         k, $time, dv[k], da[k], dc[k], db[k], dd[k],
                         m_vld[k], m_adr[k], exp_cnt, m_done[k]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic ld, input logic [31:0] v, input logic rdy);
        load = ld;
        req_vec = v;
        out_ready = rdy;
    endtask

    // Drain both instances with ready high, bounded.
    task automatic drain();
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 40 && (db != 2'b00 || dd != 2'b00); i++) tick();
        chk("drain_idle", int'(db), 0);
        tick();
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Asynchronous reset mid-cycle while a drain is in progress.
        drive(1'b1, 32'h0000_00FF, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk("pre_reset_vld", int'(dv[0]), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_vld", int'(dv), 0);
        chk("rst_adr", int'(da[0]) + int'(da[1]), 0);
        chk("rst_cnt", int'(dc[0]) + int'(dc[1]), 0);
        chk("rst_busy", int'(db), 0);
        chk("rst_done", int'(dd), 0);
        tick();
        reset = 1'b0;

        // Load of an empty mask does nothing.
        drive(1'b1, 32'h0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk("zero_vld", int'(dv), 0);
        chk("zero_busy", int'(db), 0);
        chk("zero_done", int'(dd), 0);

        // Single drain: 0,4,31 low-first; 31,4,0 high-first.
        drive(1'b1, 32'h8000_0011, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk("sd_adr0", int'(da[0]), 0);  chk("sd_cnt0", int'(dc[0]), 3);
        chk("sd_hadr0", int'(da[1]), 31);
        tick();
        chk("sd_adr1", int'(da[0]), 4);  chk("sd_cnt1", int'(dc[0]), 2);
        tick();
        chk("sd_adr2", int'(da[0]), 31); chk("sd_cnt2", int'(dc[0]), 1);
        chk("sd_hadr2", int'(da[1]), 0);
        tick();
        chk("sd_done", int'(dd[0]), 1);
        chk("sd_busy", int'(db[0]), 0);
        chk("sd_vld", int'(dv[0]), 0);
        tick();
        chk("sd_done_once", int'(dd[0]), 0);

        // Backpressure with a lower index loaded during the stall.
        drive(1'b1, 32'h0000_000C, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(1'b1, 32'h0000_0001, 1'b0);
            else        drive(1'b0, 32'h0, 1'b0);
            chk("bp_hold", int'(da[0]), 2);
            chk("bp_vld", int'(dv[0]), 1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        chk("bp_seq0", int'(da[0]), 2);
        chk("bp_cnt", int'(dc[0]), 3);
        tick();
        chk("bp_seq1", int'(da[0]), 0);
        tick();
        chk("bp_seq2", int'(da[0]), 3);
        drain();

        // Duplicate: reload bit 5 in the cycle its address is accepted.
        drive(1'b1, 32'h0000_0020, 1'b1);
        tick();
        chk("dup_first", int'(da[0]), 5);
        drive(1'b1, 32'h0000_0020, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk("dup_again", int'(da[0]), 5);
        chk("dup_vld", int'(dv[0]), 1);
        chk("dup_cnt", int'(dc[0]), 1);
        chk("dup_nodone", int'(dd[0]), 0);
        tick();
        chk("dup_done", int'(dd[0]), 1);
        tick();

        // Full mask: 32 addresses with no bubbles, done 32 cycles after first valid.
        drive(1'b1, 32'hFFFF_FFFF, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk("full_cnt", int'(dc[1]), 32);
        for (int i = 0; i < 32; i++) begin
            chk("full_hi_adr", int'(da[1]), 31 - i);
            chk("full_lo_adr", int'(da[0]), i);
            chk("full_vld", int'(dv[1]), 1);
            chk("full_nodone", int'(dd[1]), 0);
            tick();
        end
        chk("full_done", int'(dd[1]), 1);
        chk("full_busy", int'(db[1]), 0);
        tick();

        // Flush mid-drain together with a load that must be discarded.
        drive(1'b1, 32'h0000_00F0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        chk("fl_adr0", int'(da[0]), 4);
        tick();
        chk("fl_adr1", int'(da[0]), 5);
        flush = 1'b1;
        drive(1'b1, 32'h0000_0001, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        chk("fl_vld", int'(dv), 0);
        chk("fl_cnt", int'(dc[0]) + int'(dc[1]), 0);
        chk("fl_busy", int'(db), 0);
        chk("fl_done", int'(dd), 0);
        tick();
        chk("fl_load_ignored", int'(dv), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
